// File: rtl/de10_periph_regs.sv
`default_nettype none
// ============================================================================
// Module   : de10_periph_regs
// Purpose  : Memory-mapped peripheral register block for the DE10-Lite SoC.
//            Provides NUM_OUT output registers, a synchronised input port
//            with sticky rising-edge capture, a prescaled 32-bit timer with
//            compare match, and a combined registered interrupt line.
// Ports    : clk      - system clock, rising edge
//            rst      - asynchronous active-low reset
//            addr     - word address, low ADDR_LEN bits decoded
//            wr       - write strobe
//            idata    - write data
//            odata    - registered read data (1-cycle latency)
//            gpio_out - output registers, register k on [32k+31:32k]
//            gpio_in  - asynchronous external inputs
//            irq      - registered level interrupt
// Revision : 1.0 - initial release
// ============================================================================
module de10_periph_regs #(
   parameter int NUM_OUT  = 2,
   parameter int IN_W     = 8,
   parameter int ADDR_LEN = 22,
   parameter int PRESCALE = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [31:0]             addr,
   input  logic                    wr,
   input  logic [31:0]             idata,
   output logic [31:0]             odata,
   output logic [NUM_OUT*32-1:0]   gpio_out,
   input  logic [IN_W-1:0]         gpio_in,
   output logic                    irq
);

   // Register offsets following the output bank
   localparam logic [ADDR_LEN-1:0] c_A_IN    = ADDR_LEN'(NUM_OUT);
   localparam logic [ADDR_LEN-1:0] c_A_EDGE  = ADDR_LEN'(NUM_OUT + 1);
   localparam logic [ADDR_LEN-1:0] c_A_COUNT = ADDR_LEN'(NUM_OUT + 2);
   localparam logic [ADDR_LEN-1:0] c_A_CMP   = ADDR_LEN'(NUM_OUT + 3);
   localparam logic [ADDR_LEN-1:0] c_A_CTRL  = ADDR_LEN'(NUM_OUT + 4);
   localparam logic [ADDR_LEN-1:0] c_A_TSTAT = ADDR_LEN'(NUM_OUT + 5);
   localparam logic [15:0]         c_PS_MAX  = 16'(PRESCALE - 1);

   logic [ADDR_LEN-1:0] w_off;
   logic [31:0]         r_out [NUM_OUT];
   logic [IN_W-1:0]     r_sync1;
   logic [IN_W-1:0]     r_sync2;
   logic [IN_W-1:0]     r_prev;
   logic [IN_W-1:0]     r_edge;
   logic [IN_W-1:0]     w_rise;
   logic [IN_W-1:0]     w_edge_clr;
   logic [31:0]         r_count;
   logic [31:0]         r_cmp;
   logic [3:0]          r_ctrl;
   logic                r_tstat;
   logic [15:0]         r_presc;
   logic                w_tick;
   logic                w_match;
   logic                w_we_count;
   logic                w_tstat_clr;
   logic [31:0]         w_rdata;

   assign w_off = addr[ADDR_LEN-1:0];

   // Upper address bits are deliberately ignored
   generate
      if (ADDR_LEN < 32) begin : g_addr_hi
         logic w_unused_addr_hi;
         assign w_unused_addr_hi = ^addr[31:ADDR_LEN];
      end
   endgenerate

   generate
      for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
         assign gpio_out[32*k +: 32] = r_out[k];
      end
   endgenerate

   // ------------------------------------------------------------------------
   // Output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int k = 0; k < NUM_OUT; k++) r_out[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_OUT; k++) begin
            if (wr && (w_off == ADDR_LEN'(k))) r_out[k] <= idata;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Input path: two-flop synchroniser plus a delay flop for edge detection.
   // A simultaneous rise wins over a write-1-to-clear of the same bit.
   // ------------------------------------------------------------------------
   assign w_rise     = r_sync2 & ~r_prev;
   assign w_edge_clr = (wr && (w_off == c_A_EDGE)) ? idata[IN_W-1:0] : '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync1 <= '0;
         r_sync2 <= '0;
         r_prev  <= '0;
         r_edge  <= '0;
      end else begin
         r_sync1 <= gpio_in;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         r_edge  <= (r_edge & ~w_edge_clr) | w_rise;
      end
   end

   // ------------------------------------------------------------------------
   // Timer. A COUNT write overrides the tick update and restarts the
   // prescaler; the match is still judged against the pre-write count.
   // ------------------------------------------------------------------------
   assign w_tick      = r_ctrl[0] && (r_presc == c_PS_MAX);
   assign w_match     = (r_count == r_cmp);
   assign w_we_count  = wr && (w_off == c_A_COUNT);
   assign w_tstat_clr = wr && (w_off == c_A_TSTAT) && idata[0];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_presc <= '0;
      end else if (w_we_count) begin
         r_presc <= '0;
      end else if (r_ctrl[0]) begin
         r_presc <= w_tick ? 16'd0 : r_presc + 16'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= '0;
      end else if (w_we_count) begin
         r_count <= idata;
      end else if (w_tick) begin
         r_count <= (w_match && r_ctrl[1]) ? 32'd0 : r_count + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cmp   <= '0;
         r_ctrl  <= '0;
         r_tstat <= 1'b0;
      end else begin
         if (wr && (w_off == c_A_CMP))  r_cmp  <= idata;
         if (wr && (w_off == c_A_CTRL)) r_ctrl <= idata[3:0];
         r_tstat <= (r_tstat & ~w_tstat_clr) | (w_tick & w_match);
      end
   end

   // ------------------------------------------------------------------------
   // Read mux (sampled from pre-write state) and registered outputs
   // ------------------------------------------------------------------------
   always_comb begin
      w_rdata = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         if (w_off == ADDR_LEN'(k)) w_rdata = r_out[k];
      end
      if (w_off == c_A_IN)         w_rdata = 32'(r_sync2);
      else if (w_off == c_A_EDGE)  w_rdata = 32'(r_edge);
      else if (w_off == c_A_COUNT) w_rdata = r_count;
      else if (w_off == c_A_CMP)   w_rdata = r_cmp;
      else if (w_off == c_A_CTRL)  w_rdata = {28'd0, r_ctrl};
      else if (w_off == c_A_TSTAT) w_rdata = {31'd0, r_tstat};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         odata <= '0;
         irq   <= 1'b0;
      end else begin
         odata <= w_rdata;
         irq   <= (r_ctrl[2] & r_tstat) | (r_ctrl[3] & (|r_edge));
      end
   end

endmodule
`default_nettype wire
